alu_display_scan: RTL and testbench
===================================

// Module: alu_display_scan
// PURPOSE
//  Reader side of the operand registers: displays reg_a/reg_b, the ALU result or
//  the ALU flags on a 4-digit multiplexed 7-segment display (active-low anodes/segments).
//  A debounced btn_view press cycles the view. Sits between the register/ALU core
//  and the board display pins.
// PARAMETERS
//  SCAN_DIV      100000   clk cycles each digit stays lit (>=2)
//  DEBOUNCE_CYC  1000000  cycles btn_view must hold a new level before accepted (>=2)
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   reset, asynchronous, active-low
//  btn_view    in   1   raw asynchronous push-button, 1 = pressed
//  reg_a       in   8   operand A
//  reg_b       in   8   operand B
//  alu_result  in   8   ALU result
//  alu_flags   in   4   ALU flags [3:0], shown MSB on leftmost digit
//  an          out  4   digit anodes, active-low, an[3] = leftmost
//  seg         out  7   segments {g,f,e,d,c,b,a}, active-low
//  dp          out  1   decimal point, active-low
//  view        out  2   current view: 0=AB, 1=RES, 2=FLG
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low.
//  - Reset values: an=4'b1111, seg=7'h7F, dp=1, view=0; all counters 0, digit index 0.
//  - btn_view: 2-flop synchronizer -> debouncer. The debounce counter clears whenever
//    the synced level equals the stable level; otherwise it increments, and at
//    DEBOUNCE_CYC-1 stable <= synced and the counter clears. press = 1-cycle pulse on
//    stable 0->1; release makes no pulse.
//  - View FSM: AB -> RES -> FLG -> AB, one step per press pulse; code 3 is unreachable
//    and, if entered, returns to AB on the next cycle.
//  - Scan: scan_cnt counts 0..SCAN_DIV-1 and wraps; on wrap, digit index dig advances
//    0,1,2,3,0 (2-bit wrap).
//  - Digit content (inputs read live, no capture):
//      AB : d3=a[7:4] d2=a[3:0] d1=b[7:4] d0=b[3:0]; dp lit on d2 only (A|B separator)
//      RES: d3,d2 blank; d1=result[7:4] d0=result[3:0]; dp off
//      FLG: dN shows hex 0/1 of alu_flags[N]; dp off
//    Blank = seg 7'h7F. Hex (active-low, gfedcba): 0=40 1=79 2=24 3=30 4=19 5=12 6=02
//    7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
//  - an, seg, dp are registered: they reflect the dig/view/input values of the previous
//    cycle (1-cycle latency). Exactly one an bit is low at any time after the first clock
//    following reset release: an = ~(4'b0001 << dig).
//  - Simultaneous press pulse and scan wrap: both apply in the same cycle; the next
//    outputs show the new digit in the new view.
//  - Input change mid-digit: seg follows 1 cycle later; no glitch filtering.
//  - rst_n asserted mid-operation: outputs go to reset values immediately (async); a
//    pending debounce count is discarded, so a press held across reset release is seen
//    as a press once DEBOUNCE_CYC elapses.
// TESTING (bench uses SCAN_DIV=4, DEBOUNCE_CYC=8)
//  1 Reset: rst_n=0 -> an=1111, seg=7F, dp=1, view=0; release -> an=1110 on 2nd clk.
//  2 AB scan: a=8'h3C, b=8'hA5 -> digits d0..d3 show 0x12,0x08,0x46,0x30 (seg), each
//    for 4 cycles; dp=0 only while an=1011.
//  3 Debounce: btn toggles every 3 cycles for 40 cycles -> view stays 0; btn held 1 for
//    >=12 cycles -> view=1 exactly once; held another 50 cycles -> no further change.
//  4 RES/FLG: result=8'h7F, flags=4'b1010, step views -> RES: an3/an2 digits 7F,
//    d1=78, d0=0E; FLG: d3=79 d2=40 d1=79 d0=40; third press -> view=0.
//  5 Collision/reset: align press pulse with scan wrap -> next cycle shows new view on
//    new digit; assert rst_n mid-digit in FLG -> immediate reset values, view=0.

Source files
------------

// File: rtl/alu_display_scan.sv
// Drives a 4-digit multiplexed 7-segment display with operands, ALU result or flags; a debounced button cycles the view.
// Latency: an/seg/dp are registered one cycle after dig/view/inputs. No backpressure; display pins update every cycle.
module alu_display_scan #(
  parameter int SCAN_DIV     = 100000,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_view,
  input  logic [7:0] reg_a,
  input  logic [7:0] reg_b,
  input  logic [7:0] alu_result,
  input  logic [3:0] alu_flags,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] view
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    V_AB  = 2'd0,
    V_RES = 2'd1,
    V_FLG = 2'd2,
    V_BAD = 2'd3
  } view_e;

  logic [1:0]    sync_q;
  logic          stable_q, stable_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          press;
  view_e         view_q, view_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]    dig_q, dig_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    nib;
  logic          blank;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Counter only runs while the synced level disagrees with the accepted level.
  always_comb begin
    stable_d  = stable_q;
    deb_cnt_d = '0;
    press     = 1'b0;
    if (sync_q[1] != stable_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        stable_d = sync_q[1];
        press    = sync_q[1];
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    view_d = view_q;
    case (view_q)
      V_AB:    if (press) view_d = V_RES;
      V_RES:   if (press) view_d = V_FLG;
      V_FLG:   if (press) view_d = V_AB;
      default: view_d = V_AB;
    endcase
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    dig_d      = dig_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      dig_d      = dig_q + 2'd1;
    end
  end

  always_comb begin
    nib   = 4'h0;
    blank = 1'b1;
    dp_d  = 1'b1;
    case (view_q)
      V_AB: begin
        blank = 1'b0;
        dp_d  = (dig_q != 2'd2);
        case (dig_q)
          2'd3:    nib = reg_a[7:4];
          2'd2:    nib = reg_a[3:0];
          2'd1:    nib = reg_b[7:4];
          default: nib = reg_b[3:0];
        endcase
      end
      V_RES: begin
        if (!dig_q[1]) begin
          blank = 1'b0;
          nib   = dig_q[0] ? alu_result[7:4] : alu_result[3:0];
        end
      end
      V_FLG: begin
        blank = 1'b0;
        nib   = {3'b000, alu_flags[dig_q]};
      end
      default: ;
    endcase
    seg_d = blank ? 7'h7F : hex7(nib);
    an_d  = ~(4'b0001 << dig_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= 2'b00;
      stable_q   <= 1'b0;
      deb_cnt_q  <= '0;
      view_q     <= V_AB;
      scan_cnt_q <= '0;
      dig_q      <= 2'd0;
      an_q       <= 4'b1111;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
    end else begin
      sync_q     <= {sync_q[0], btn_view};
      stable_q   <= stable_d;
      deb_cnt_q  <= deb_cnt_d;
      view_q     <= view_d;
      scan_cnt_q <= scan_cnt_d;
      dig_q      <= dig_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = dp_q;
  assign view = view_q;

endmodule

// File: tb/tb_alu_display_scan.sv
// Scoreboard bench: a cycle-level reference model predicts every display output; a monitor compares on the falling edge.
module tb_alu_display_scan;
  localparam int SD = 4;
  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn = 1'b0;
  logic [7:0] a = 8'h3C;
  logic [7:0] b = 8'hA5;
  logic [7:0] res = 8'h7F;
  logic [3:0] flg = 4'b1010;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] view;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] view;
  } exp_t;

  exp_t q[$];
  logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  alu_display_scan #(.SCAN_DIV(SD), .DEBOUNCE_CYC(DB)) dut (
    .clk(clk), .rst_n(rst_n), .btn_view(btn),
    .reg_a(a), .reg_b(b), .alu_result(res), .alu_flags(flg),
    .an(an), .seg(seg), .dp(dp), .view(view)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: digit from elapsed cycles, view from accepted press count.
  initial begin
    int n;
    int presses;
    int d;
    int v;
    logic s1, s2, stable, synced;
    bit all;
    logic hist[$];
    logic [15:0] ab;
    exp_t e;
    n = 0; presses = 0; s1 = 0; s2 = 0; stable = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        n = 0; presses = 0; s1 = 0; s2 = 0; stable = 0;
        hist.delete();
        q.delete();
      end else begin
        d = (n / SD) % 4;
        v = presses % 3;
        e.an  = 4'(~(4'b0001 << d));
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        if (v == 0) begin
          ab = {a, b};
          e.seg = HEX[4'(ab >> (4 * d))];
          e.dp  = (d != 2);
        end else if (v == 1) begin
          if (d < 2) e.seg = HEX[4'(res >> (4 * d))];
        end else begin
          e.seg = flg[d] ? HEX[1] : HEX[0];
        end
        synced = s2; s2 = s1; s1 = btn;
        hist.push_back(synced);
        if (hist.size() > DB) void'(hist.pop_front());
        if (hist.size() == DB && synced != stable) begin
          all = 1'b1;
          foreach (hist[i]) if (hist[i] != synced) all = 1'b0;
          if (all) begin
            stable = synced;
            if (stable) presses++;
          end
        end
        e.view = 2'(presses % 3);
        n++;
        q.push_back(e);
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n || q.size() == 0) begin
        chk("rst_an", 16'(an), 16'hF);
        chk("rst_seg", 16'(seg), 16'h7F);
        chk("rst_dp", 16'(dp), 16'h1);
        chk("rst_view", 16'(view), 16'h0);
      end else begin
        e = q.pop_front();
        chk("an", 16'(an), 16'(e.an));
        chk("seg", 16'(seg), 16'(e.seg));
        chk("dp", 16'(dp), 16'(e.dp));
        chk("view", 16'(view), 16'(e.view));
      end
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic press();
    btn = 1'b1;
    cyc(12);
    btn = 1'b0;
    cyc(12);
  endtask

  initial begin
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    chk("an_after_release", 16'(an), 16'hE);
    cyc(22);
    for (int i = 0; i < 14; i++) begin
      btn = ~btn;
      cyc(3);
    end
    btn = 1'b0;
    cyc(12);
    chk("view_noise", 16'(view), 16'h0);
    btn = 1'b1;
    cyc(14);
    chk("view_press1", 16'(view), 16'h1);
    cyc(50);
    chk("view_hold", 16'(view), 16'h1);
    btn = 1'b0;
    cyc(12);
    chk("view_release", 16'(view), 16'h1);
    press();
    chk("view_flg", 16'(view), 16'h2);
    cyc(20);
    press();
    chk("view_wrap", 16'(view), 16'h0);
    for (int off = 0; off < 4; off++) begin
      cyc(off + 1);
      press();
    end
    chk("view_collide", 16'(view), 16'h1);
    repeat (40) begin
      a   = 8'($urandom);
      b   = 8'($urandom);
      res = 8'($urandom);
      flg = 4'($urandom);
      btn = 1'($urandom_range(0, 1));
      cyc($urandom_range(1, 14));
    end
    btn = 1'b0;
    cyc(12);
    for (int i = 0; i < 3 && view != 2'd2; i++) press();
    chk("view_flg_pre_rst", 16'(view), 16'h2);
    cyc(5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_an", 16'(an), 16'hF);
    chk("mid_rst_seg", 16'(seg), 16'h7F);
    chk("mid_rst_dp", 16'(dp), 16'h1);
    chk("mid_rst_view", 16'(view), 16'h0);
    btn = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(14);
    chk("view_held_over_rst", 16'(view), 16'h1);
    btn = 1'b0;
    cyc(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
